display_scan_driver: RTL

// - Downstream of the calculator top. Consumes its 16-bit display channel, canal_pantalla, and drives the
//   8-digit multiplexed 7-segment display. Anodes and segments are active-low.
// - Shows the value in hex (4 digits) or decimal (5 digits). Decimal uses a sequential shift-add-3 BCD

---
 rtl/display_pkg.sv | 32 +++
 rtl/display_scan_driver_bin2bcd.sv | 45 ++++
 rtl/display_scan_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, constants and segment decoder for the display scan driver
package display_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/display_scan_driver_bin2bcd.sv
// rtl/display_scan_driver_bin2bcd.sv - sequential 16-bit binary to 5-digit BCD converter (shift-add-3)
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);
    logic [35:0] r_sr;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [35:0] w_adj;

    always_comb begin
        w_adj = r_sr;
        for (int i = 0; i < 5; i++) begin
            if (r_sr[16+4*i +: 4] >= 4'd5)
                w_adj[16+4*i +: 4] = r_sr[16+4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_sr   <= {20'd0, bin};
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_sr  <= {w_adj[34:0], 1'b0};
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15)
                r_busy <= 1'b0;
        end
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == 4'd15);
    assign bcd  = r_sr[35:16];

endmodule

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - multiplexed 8-digit 7-segment driver showing a 16-bit value in hex or decimal
module display_scan_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           value,
    input  logic                  dec_mode,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  busy
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    conv_state_t r_state, w_next;
    logic [15:0]           r_last_value;
    logic                  r_last_mode;
    logic                  r_pending;
    logic [19:0]           r_dig;
    logic [CNT_W-1:0]      r_refresh;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;

    logic        w_change, w_want, w_latch, w_load, w_done, w_bcd_busy;
    logic [19:0] w_bcd;
    logic [3:0]  w_nib;
    logic [IDX_W-1:0] w_msd;

    assign w_change = {value, dec_mode} != {r_last_value, r_last_mode};
    assign w_want   = r_pending | w_change;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_latch),
        .bin   (value),
        .busy  (w_bcd_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_load  = 1'b0;
        case (r_state)
            IDLE: if (w_want) begin
                w_latch = 1'b1;
                w_next  = SHIFT;
            end
            SHIFT: if (w_done) w_next = LOAD;
            LOAD: begin
                w_load = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_value <= '0;
            r_last_mode  <= 1'b0;
            r_pending    <= 1'b0;
            r_dig        <= '0;
        end else begin
            r_state   <= w_next;
            r_pending <= w_latch ? 1'b0 : w_want;
            if (w_latch) begin
                r_last_value <= value;
                r_last_mode  <= dec_mode;
            end
            // Hex leaves digit 4 at zero so leading-zero blanking also covers the mode limit
            if (w_load)
                r_dig <= r_last_mode ? w_bcd : {4'd0, r_last_value};
        end
    end

    always_comb begin
        w_msd = '0;
        for (int i = 1; i < 5; i++) begin
            if (r_dig[4*i +: 4] != 4'd0)
                w_msd = IDX_W'(i);
        end
    end

    assign w_nib = 4'(r_dig >> {r_idx, 2'b00});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_an      <= '1;
            r_seg     <= SEG_BLANK;
        end else begin
            if (r_refresh == CNT_W'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= (r_idx > w_msd) ? SEG_BLANK : seg_decode(w_nib);
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = 1'b1;
    assign busy = (r_state != IDLE) | w_bcd_busy;

endmodule
